logical_op_pipe: RTL and testbench

Pipelined, multi-lane successor to the single-result logical AND unit: each lane reduces two N-bit operands to booleans and combines them with a run-time-selected logical operator (AND/OR/XOR and their inversions). An optional accumulate mode folds results across a multi-beat packet. A valid/ready stream interface with full backpressure lets it sit between stream stages in the BasicCombinationalLogic datapath.

---
 rtl/logical_pkg.sv | 36 +++
 rtl/logical_lane.sv | 15 +
 rtl/logical_op_pipe.sv | 154 +++++++++++++++
 tb/tb_logical_op_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logical_pkg.sv
// Shared types and helpers for the pipelined logical operator unit.
// Opcode bit 2 inverts the result; bits [1:0] pick the base operator.
package logical_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110
    } op_e;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } pkt_state_e;

    localparam int         OP_INV_BIT = 2;
    localparam logic [7:0] BEATS_MAX  = 8'd255;

    function automatic logic is_reserved(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

    // Base operator only; a reserved base yields 0.
    function automatic logic base_fold(input logic [1:0] op, input logic acc, input logic x);
        case (op)
            2'b00:   return acc & x;
            2'b01:   return acc | x;
            2'b10:   return acc ^ x;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/logical_lane.sv
// One lane: reduce both operands to booleans and apply the base operator.
module logical_lane
    import logical_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   base_op,
    output logic         x
);

    assign x = base_fold(base_op, |a, |b);

endmodule

// File: rtl/logical_op_pipe.sv
// Multi-lane logical operator with packet accumulate, two register stages
// (S1 lane reduce, S2 fold + output register) and valid/ready backpressure.
module logical_op_pipe
    import logical_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic               in_acc,
    input  logic               in_last,
    input  logic [LANES*N-1:0] in_a,
    input  logic [LANES*N-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES-1:0]   out_c,
    output logic               out_err,
    output logic [7:0]         out_beats
);

    logic             rdy_en;
    pkt_state_e       state, state_n;
    logic [2:0]       pkt_op;
    logic             pkt_acc;
    logic             is_first;
    logic [2:0]       eff_op;
    logic             eff_acc, eff_last;
    logic [LANES-1:0] lane_x;

    logic             s1_valid, s1_ready, s1_go, s2_ready, in_fire;
    logic [LANES-1:0] s1_x;
    logic [2:0]       s1_op;
    logic             s1_err, s1_first, s1_last;

    logic [LANES-1:0] acc_q, fold_x, res_c;
    logic             acc_err, err_n;
    logic [7:0]       acc_beats, beats_n;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign s1_go    = s1_valid && s2_ready;
    assign in_ready = rdy_en && s1_ready;
    assign in_fire  = in_valid && in_ready;

    // Packet FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FIRST;
        else        state <= state_n;
    end

    // Packet FSM: next state
    always_comb begin
        state_n = state;
        if (in_fire) state_n = eff_last ? ST_FIRST : ST_MID;
    end

    // Packet FSM: outputs; op/acc come from the first beat of a packet
    always_comb begin
        is_first = (state == ST_FIRST);
        eff_op   = is_first ? in_op  : pkt_op;
        eff_acc  = is_first ? in_acc : pkt_acc;
        eff_last = !eff_acc || in_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_op  <= 3'b000;
            pkt_acc <= 1'b0;
        end else if (in_fire && is_first) begin
            pkt_op  <= in_op;
            pkt_acc <= in_acc;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logical_lane #(.N(N)) u_lane (
            .a       (in_a[k*N +: N]),
            .b       (in_b[k*N +: N]),
            .base_op (eff_op[1:0]),
            .x       (lane_x[k])
        );
    end

    // S1: per-lane base results plus packet position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_op    <= 3'b000;
            s1_err   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_x     <= lane_x;
                s1_op    <= eff_op;
                s1_err   <= is_reserved(eff_op);
                s1_first <= is_first;
                s1_last  <= eff_last;
            end
        end
    end

    // S2 fold: a first beat restarts from its own result, never the old accumulator
    always_comb begin
        err_n   = s1_err | (!s1_first && acc_err);
        beats_n = s1_first ? 8'd1 :
                  (acc_beats == BEATS_MAX) ? BEATS_MAX : acc_beats + 8'd1;
        for (int k = 0; k < LANES; k++)
            fold_x[k] = s1_first ? s1_x[k] : base_fold(s1_op[1:0], acc_q[k], s1_x[k]);
        res_c = err_n ? '0 : (s1_op[OP_INV_BIT] ? ~fold_x : fold_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_err   <= 1'b0;
            acc_beats <= 8'd0;
        end else if (s1_go) begin
            acc_q     <= fold_x;
            acc_err   <= err_n;
            acc_beats <= beats_n;
        end
    end

    // Output register holds until popped; absorbed beats never touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_err   <= 1'b0;
            out_beats <= 8'd0;
        end else if (s1_go && s1_last) begin
            out_valid <= 1'b1;
            out_c     <= res_c;
            out_err   <= err_n;
            out_beats <= beats_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logical_op_pipe.sv
// Directed bench for logical_op_pipe: N=8, LANES=4.
module tb_logical_op_pipe;

    logic        clk = 0, rst_n = 1;
    logic        in_valid = 0, in_ready;
    logic [2:0]  in_op = 3'b000;
    logic        in_acc = 0, in_last = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic        out_valid, out_ready = 1;
    logic [3:0]  out_c;
    logic        out_err;
    logic [7:0]  out_beats;

    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {
        logic [3:0] c;
        logic       err;
        logic [7:0] beats;
        int         cyc;
    } res_t;
    res_t q[$];
    res_t mon_r;

    logical_op_pipe #(.N(8), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_err(out_err), .out_beats(out_beats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_r.c = out_c; mon_r.err = out_err; mon_r.beats = out_beats; mon_r.cyc = cyc;
            q.push_back(mon_r);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 right after the beat is taken.
    task automatic send(input logic [2:0] op, input logic acc, input logic last,
                        input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        in_valid = 1; in_op = op; in_acc = acc; in_last = last; in_a = a; in_b = b;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; @(negedge clk); w++;
        end
        n_chk++;
        if (!in_ready) begin n_fail++; $display("FAIL send_timeout in_ready=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_q(input int n);
        int i = 0;
        do begin @(posedge clk); #1; i++; end while (q.size() < n && i < 400);
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (out_c !== 4'b0000) begin n_fail++; $display("FAIL rst_out_c got=%b exp=0000", out_c); end
        n_chk++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
        n_chk++; if (out_beats !== 8'd0) begin n_fail++; $display("FAIL rst_out_beats got=%0d exp=0", out_beats); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_held_in_ready got=%b exp=0", in_ready); end
        rst_n = 1;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        q.delete();
        send(3'b000, 0, 0, 32'h00FF_0001, 32'h0100_0000);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got=%b exp=1", out_valid); end
        n_chk++; if (out_c !== 4'b0000) begin n_fail++; $display("FAIL basic_and0 got=%b exp=0000", out_c); end
        n_chk++; if (out_beats !== 8'd1) begin n_fail++; $display("FAIL basic_beats0 got=%0d exp=1", out_beats); end
        send(3'b000, 0, 1, 32'h00FF_0001, 32'h0101_0101);
        wait_q(2);
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", q.size()); end
        if (q.size() >= 2) begin
            n_chk++; if (q[1].c !== 4'b0101) begin n_fail++; $display("FAIL basic_and1 got=%b exp=0101", q[1].c); end
            n_chk++; if (q[1].beats !== 8'd1) begin n_fail++; $display("FAIL basic_beats1 got=%0d exp=1", q[1].beats); end
            n_chk++; if (q[1].err !== 1'b0) begin n_fail++; $display("FAIL basic_err1 got=%b exp=0", q[1].err); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[5] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        logic [31:0] bs[5]  = '{32'h0100_0000, 32'h0101_0101, 32'h0101_0101, 32'h0100_0000, 32'h0101_0101};
        logic [3:0]  exp[5] = '{4'b1101, 4'b1010, 4'b1010, 4'b0010, 4'b0101};
        q.delete();
        for (int i = 0; i < 5; i++) send(ops[i], 0, 0, 32'h00FF_0001, bs[i]);
        wait_q(5);
        n_chk++; if (q.size() != 5) begin n_fail++; $display("FAIL b2b_count got=%0d exp=5", q.size()); end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            n_chk++; if (q[i].c !== exp[i]) begin n_fail++; $display("FAIL b2b_c%0d got=%b exp=%b", i, q[i].c, exp[i]); end
            if (i > 0) begin
                n_chk++;
                if (q[i].cyc != q[0].cyc + i) begin
                    n_fail++; $display("FAIL b2b_rate%0d got_cycle=%0d exp_cycle=%0d", i, q[i].cyc, q[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_acc_xnor();
        q.delete();
        send(3'b110, 1, 0, 32'h0000_0101, 32'h0000_0000);
        send(3'b000, 0, 0, 32'h0000_0000, 32'h0000_0001);
        send(3'b000, 0, 1, 32'h0000_0001, 32'h0000_0001);
        wait_q(1);
        repeat (4) begin @(posedge clk); #1; end
        n_chk++; if (q.size() != 1) begin n_fail++; $display("FAIL xnor_count got=%0d exp=1", q.size()); end
        if (q.size() >= 1) begin
            n_chk++; if (q[0].c !== 4'b1101) begin n_fail++; $display("FAIL xnor_c got=%b exp=1101", q[0].c); end
            n_chk++; if (q[0].beats !== 8'd3) begin n_fail++; $display("FAIL xnor_beats got=%0d exp=3", q[0].beats); end
            n_chk++; if (q[0].err !== 1'b0) begin n_fail++; $display("FAIL xnor_err got=%b exp=0", q[0].err); end
        end
    endtask

    task automatic test_single_acc();
        q.delete();
        send(3'b001, 1, 1, 32'h00FF_0001, 32'h0100_0000);
        send(3'b000, 0, 0, 32'h00FF_0001, 32'h0101_0101);
        wait_q(2);
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL single_count got=%0d exp=2", q.size()); end
        if (q.size() >= 2) begin
            n_chk++; if (q[0].c !== 4'b1101) begin n_fail++; $display("FAIL single_c got=%b exp=1101", q[0].c); end
            n_chk++; if (q[0].beats !== 8'd1) begin n_fail++; $display("FAIL single_beats got=%0d exp=1", q[0].beats); end
            n_chk++; if (q[1].c !== 4'b0101) begin n_fail++; $display("FAIL single_next_c got=%b exp=0101", q[1].c); end
        end
    endtask

    task automatic test_reserved();
        q.delete();
        send(3'b011, 1, 0, 32'hFFFF_FFFF, 32'h0000_0000);
        send(3'b001, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(3'b001, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_q(2);
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL rsv_count got=%0d exp=2", q.size()); end
        if (q.size() >= 2) begin
            n_chk++; if (q[0].c !== 4'b0000) begin n_fail++; $display("FAIL rsv_c got=%b exp=0000", q[0].c); end
            n_chk++; if (q[0].err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got=%b exp=1", q[0].err); end
            n_chk++; if (q[0].beats !== 8'd2) begin n_fail++; $display("FAIL rsv_beats got=%0d exp=2", q[0].beats); end
            n_chk++; if (q[1].err !== 1'b0) begin n_fail++; $display("FAIL rsv_next_err got=%b exp=0", q[1].err); end
            n_chk++; if (q[1].c !== 4'b1111) begin n_fail++; $display("FAIL rsv_next_c got=%b exp=1111", q[1].c); end
        end
    endtask

    task automatic test_backpressure();
        q.delete();
        out_ready = 0;
        send(3'b001, 0, 0, 32'h0000_0001, 32'h0000_0000);
        send(3'b001, 0, 0, 32'h0000_0100, 32'h0000_0000);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        in_valid = 1; in_a = 32'h0001_0000; in_b = 32'h0;
        repeat (3) begin
            @(negedge clk);
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_in_ready got=%b exp=0", in_ready); end
            n_chk++; if (out_valid !== 1'b1 || out_c !== 4'b0001) begin
                n_fail++; $display("FAIL bp_hold got_valid=%b got_c=%b exp_valid=1 exp_c=0001", out_valid, out_c);
            end
            @(posedge clk); #1;
        end
        out_ready = 1;
        send(3'b001, 0, 0, 32'h0001_0000, 32'h0000_0000);
        send(3'b001, 0, 0, 32'h0100_0000, 32'h0000_0000);
        wait_q(4);
        repeat (4) begin @(posedge clk); #1; end
        n_chk++; if (q.size() != 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            logic [3:0] e;
            e = 4'b0001 << i;
            n_chk++; if (q[i].c !== e) begin n_fail++; $display("FAIL bp_order%0d got=%b exp=%b", i, q[i].c, e); end
        end
    endtask

    task automatic test_reset_mid();
        q.delete();
        send(3'b000, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1; in_op = 3'b000; in_acc = 1; in_last = 0;
        #2 rst_n = 0;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        in_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        send(3'b001, 0, 0, 32'h0000_00FF, 32'h0000_0000);
        wait_q(1);
        repeat (3) begin @(posedge clk); #1; end
        n_chk++; if (q.size() != 1) begin n_fail++; $display("FAIL rmid_count got=%0d exp=1", q.size()); end
        if (q.size() >= 1) begin
            n_chk++; if (q[0].c !== 4'b0001) begin n_fail++; $display("FAIL rmid_c got=%b exp=0001", q[0].c); end
            n_chk++; if (q[0].beats !== 8'd1) begin n_fail++; $display("FAIL rmid_beats got=%0d exp=1", q[0].beats); end
        end
    endtask

    task automatic test_saturate();
        q.delete();
        for (int i = 0; i < 300; i++)
            send(3'b001, 1, (i == 299), (i == 5) ? 32'h0001_0000 : 32'h0, 32'h0);
        wait_q(1);
        repeat (3) begin @(posedge clk); #1; end
        n_chk++; if (q.size() != 1) begin n_fail++; $display("FAIL sat_count got=%0d exp=1", q.size()); end
        if (q.size() >= 1) begin
            n_chk++; if (q[0].beats !== 8'd255) begin n_fail++; $display("FAIL sat_beats got=%0d exp=255", q[0].beats); end
            n_chk++; if (q[0].c !== 4'b0100) begin n_fail++; $display("FAIL sat_c got=%b exp=0100", q[0].c); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_acc_xnor();
        test_single_acc();
        test_reserved();
        test_backpressure();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
